// File: rtl/hazard_sched_pkg.sv
// ----------------------------------------------------------------------------
// hazard_sched_pkg
//  Shared types and constants for the pipeline stall/flush scheduler.
//  - hazard_state_e : scheduler FSM states
//  - STG_IF..STG_WB : bit positions of each stage in stage_adv/stage_flush
// ----------------------------------------------------------------------------
package hazard_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_REDIR_WAIT = 2'd1,
    ST_TRAP_DRAIN = 2'd2
  } hazard_state_e;

  localparam int NUM_STG = 5;
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/hazard_sched_perf_cnt.sv
// ----------------------------------------------------------------------------
// hazard_perf_cnt
//  Two saturating event counters for the hazard scheduler (built only when
//  PERF_CNT_EN is defined in the enclosing design).
//  Ports:
//   clk, rst          clock, synchronous active-high reset (clears counters)
//   stall_inc_i       count one EXE stall cycle
//   flush_inc_i       count one accepted branch/trap flush
//   stall_cnt_o       stall cycle count, saturates at all-ones
//   flush_cnt_o       flush initiation count, saturates at all-ones
// ----------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_inc_i,
  input  logic         flush_inc_i,
  output logic [W-1:0] stall_cnt_o,
  output logic [W-1:0] flush_cnt_o
);

  logic [W-1:0] stall_q, stall_d;
  logic [W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (flush_inc_i && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: rtl/hazard_sched.sv
// ----------------------------------------------------------------------------
// hazard_sched
//  Central stall/flush scheduler for the 5-stage pipe (IF,ID,EXE,MEM,WB).
//  Builds the advance chain, sequences EXE branch redirects and MEM traps,
//  and holds a redirect until the fetch bus is idle.
//  Optional feature macro: PERF_CNT_EN (adds perf_stall/perf_flush counters).
//  Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_ready/id_ready/exe_done/fw_valid/mem_ready/wb_ready  stage status
//   if_busy, mem_inflight      ibus / dbus transaction outstanding
//   br_redirect, br_target     EXE mispredict and corrected PC
//   trap_req, trap_target      MEM trap and trap vector
//   stage_adv, stage_flush     per-stage advance/flush, bit0=IF .. bit4=WB
//   pc_redirect, pc_target     redirect command to IF
//   busy                       scheduler is not in RUN
//   dbg_state                  current FSM state
//   perf_stall, perf_flush     (PERF_CNT_EN only) saturating counters
//
//  Handshake: pc_redirect is a single-cycle command with no ready; IF must
//  load pc_target in the cycle pc_redirect=1. It is only issued while
//  if_busy=0, and never in two consecutive cycles. pc_target holds its last
//  value otherwise. The EXE forwarding logic sees exe_ready=stage_adv[2] and
//  exe_flush=stage_flush[2].
// ----------------------------------------------------------------------------
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int XLEN = 64
`ifdef PERF_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_ready,
  input  logic               if_busy,
  input  logic               id_ready,
  input  logic               exe_done,
  input  logic               fw_valid,
  input  logic               mem_ready,
  input  logic               mem_inflight,
  input  logic               wb_ready,
  input  logic               br_redirect,
  input  logic [XLEN-1:0]    br_target,
  input  logic               trap_req,
  input  logic [XLEN-1:0]    trap_target,
  output logic [NUM_STG-1:0] stage_adv,
  output logic [NUM_STG-1:0] stage_flush,
  output logic               pc_redirect,
  output logic [XLEN-1:0]    pc_target,
  output logic               busy,
  output hazard_state_e      dbg_state
`ifdef PERF_CNT_EN
  , output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0]   perf_flush
`endif
);

  hazard_state_e       state_q, state_d;
  logic [XLEN-1:0]     pend_q, pend_d;
  logic [XLEN-1:0]     tgt_q, tgt_d;
  logic                redir_q;

  logic [NUM_STG-1:0]  adv_chain;
  logic [NUM_STG-1:0]  adv_mask;
  logic [NUM_STG-1:0]  flush;
  logic                redir;
  logic [XLEN-1:0]     redir_tgt;
  logic                issue;
  logic [XLEN-1:0]     issue_tgt;

  // A stage advances only when it and every younger-facing stage behind it
  // can move.
  always_comb begin
    adv_chain[STG_WB]  = wb_ready;
    adv_chain[STG_MEM] = mem_ready & adv_chain[STG_WB];
    adv_chain[STG_EXE] = exe_done & fw_valid & adv_chain[STG_MEM];
    adv_chain[STG_ID]  = id_ready & adv_chain[STG_EXE];
    adv_chain[STG_IF]  = if_ready & adv_chain[STG_ID];
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    adv_mask  = '1;
    flush     = '0;
    redir     = 1'b0;
    redir_tgt = pend_q;
    issue     = 1'b0;
    issue_tgt = pend_q;

    case (state_q)
      ST_RUN, ST_REDIR_WAIT: begin
        if (state_q == ST_REDIR_WAIT) begin
          // IF drops whatever the outstanding fetch returns.
          adv_mask[STG_IF] = 1'b0;
          flush[STG_IF]    = 1'b1;
        end
        if (trap_req) begin
          // Trap wins over any branch and replaces a pending redirect.
          if (mem_inflight) begin
            pend_d                   = trap_target;
            adv_mask[STG_MEM:STG_IF] = '0;
            state_d                  = ST_TRAP_DRAIN;
          end else begin
            flush[STG_MEM:STG_IF] = '1;
            issue                 = 1'b1;
            issue_tgt             = trap_target;
          end
        end else if (state_q == ST_REDIR_WAIT) begin
          issue     = 1'b1;
          issue_tgt = pend_q;
        end else if (br_redirect && adv_chain[STG_EXE]) begin
          // The branch itself moves on; only the younger IF/ID are killed.
          flush[STG_ID:STG_IF] = '1;
          issue                = 1'b1;
          issue_tgt            = br_target;
        end
      end
      ST_TRAP_DRAIN: begin
        adv_mask[STG_MEM:STG_IF] = '0;
        if (!mem_inflight) begin
          flush[STG_MEM:STG_IF] = '1;
          issue                 = 1'b1;
          issue_tgt             = pend_q;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Redirect now if the fetch bus is idle and no redirect went out last
    // cycle; otherwise park the target and retry from REDIR_WAIT.
    if (issue) begin
      if (!if_busy && !redir_q) begin
        redir     = 1'b1;
        redir_tgt = issue_tgt;
        state_d   = ST_RUN;
      end else begin
        pend_d  = issue_tgt;
        state_d = ST_REDIR_WAIT;
      end
    end
  end

  assign tgt_d = redir ? redir_tgt : tgt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pend_q  <= '0;
      tgt_q   <= '0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      redir_q <= redir;
    end
  end

  // Flush dominates advance on the same stage.
  assign stage_adv   = rst ? '0 : (adv_chain & adv_mask & ~flush);
  assign stage_flush = rst ? '1 : flush;
  assign pc_redirect = ~rst & redir;
  assign pc_target   = rst ? '0 : tgt_d;
  assign busy        = ~rst & (state_q != ST_RUN);
  assign dbg_state   = state_q;

`ifdef PERF_CNT_EN
  // Every accepted branch/trap flush kills ID, while REDIR_WAIT alone only
  // flushes IF, so the ID flush bit marks a flush initiation.
  hazard_perf_cnt #(.W(PERF_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_inc_i (~rst & ~stage_adv[STG_EXE]),
    .flush_inc_i (~rst & stage_flush[STG_ID]),
    .stall_cnt_o (perf_stall),
    .flush_cnt_o (perf_flush)
  );
`endif

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_ready, if_busy, id_ready, exe_done, fw_valid;
  logic            mem_ready, mem_inflight, wb_ready;
  logic            br_redirect, trap_req;
  logic [XLEN-1:0] br_target, trap_target;
  logic [4:0]      stage_adv, stage_flush;
  logic            pc_redirect, busy;
  logic [XLEN-1:0] pc_target;
  logic [1:0]      dbg_state;
`ifdef PERF_CNT_EN
  logic [31:0]     perf_stall, perf_flush;
`endif

  always #5 clk = ~clk;

  hazard_sched dut (
    .clk          (clk),
    .rst          (rst),
    .if_ready     (if_ready),
    .if_busy      (if_busy),
    .id_ready     (id_ready),
    .exe_done     (exe_done),
    .fw_valid     (fw_valid),
    .mem_ready    (mem_ready),
    .mem_inflight (mem_inflight),
    .wb_ready     (wb_ready),
    .br_redirect  (br_redirect),
    .br_target    (br_target),
    .trap_req     (trap_req),
    .trap_target  (trap_target),
    .stage_adv    (stage_adv),
    .stage_flush  (stage_flush),
    .pc_redirect  (pc_redirect),
    .pc_target    (pc_target),
    .busy         (busy),
    .dbg_state    (dbg_state)
`ifdef PERF_CNT_EN
    , .perf_stall (perf_stall),
    .perf_flush   (perf_flush)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Scheduler mode is kept as two flags: "a redirect is parked" and
  // "waiting for the dbus to drain before a trap flush".
  bit              m_wait, m_drain, m_prev_redir;
  logic [XLEN-1:0] m_pend, m_last;
  bit              n_wait, n_drain, n_prev_redir;
  logic [XLEN-1:0] n_pend, n_last;
  logic [4:0]      e_adv, e_flush;
  bit              e_redir, e_busy;
  logic [XLEN-1:0] e_tgt;
  longint          m_stall, m_flushcnt, n_stall, n_flushcnt;

  task automatic model_eval();
    logic [4:0]      rdy, chain, mask, fl;
    logic            ok, go, init;
    logic [XLEN-1:0] gt;
    rdy = {wb_ready, mem_ready, exe_done & fw_valid, id_ready, if_ready};
    ok  = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      ok       = ok & rdy[k];
      chain[k] = ok;
    end
    mask = 5'b11111; fl = 5'b0; go = 0; init = 0; gt = m_pend;
    n_wait = m_wait; n_drain = m_drain; n_pend = m_pend;
    if (m_drain) begin
      mask = 5'b10000;
      if (!mem_inflight) begin fl = 5'b01111; go = 1; gt = m_pend; init = 1; end
    end else begin
      if (m_wait) begin mask = 5'b11110; fl = 5'b00001; end
      if (trap_req) begin
        if (mem_inflight) begin
          mask = 5'b10000; n_drain = 1; n_wait = 0; n_pend = trap_target;
        end else begin
          fl = fl | 5'b01111; go = 1; gt = trap_target; init = 1;
        end
      end else if (m_wait) begin
        go = 1; gt = m_pend;
      end else if (br_redirect && chain[2]) begin
        fl = 5'b00011; go = 1; gt = br_target; init = 1;
      end
    end
    e_redir = 0;
    if (go) begin
      if (!if_busy && !m_prev_redir) begin
        e_redir = 1; n_wait = 0; n_drain = 0;
      end else begin
        n_pend = gt; n_wait = 1; n_drain = 0;
      end
    end
    e_adv   = chain & mask & ~fl;
    e_flush = fl;
    e_tgt   = e_redir ? gt : m_last;
    e_busy  = m_wait | m_drain;
    n_last  = e_tgt;
    n_prev_redir = e_redir;
    n_stall    = m_stall + ((e_adv[2] == 1'b0) ? 1 : 0);
    n_flushcnt = m_flushcnt + (init ? 1 : 0);
    if (rst) begin
      e_adv = 5'b0; e_flush = 5'b11111; e_redir = 0; e_tgt = '0; e_busy = 0;
      n_wait = 0; n_drain = 0; n_pend = '0; n_last = '0; n_prev_redir = 0;
      n_stall = 0; n_flushcnt = 0;
    end
  endtask

  task automatic model_check();
    chk("model_adv",      stage_adv,   e_adv);
    chk("model_flush",    stage_flush, e_flush);
    chk("model_redirect", pc_redirect, e_redir);
    chk("model_target",   pc_target,   e_tgt);
    chk("model_busy",     busy,        e_busy);
    chk("no_back_to_back", pc_redirect & m_prev_redir, 0);
`ifdef PERF_CNT_EN
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_flush", perf_flush, m_flushcnt);
`endif
  endtask

  // Sample at the falling edge, then let the model follow the rising edge.
  task automatic tick();
    @(negedge clk);
    model_eval();
    model_check();
  endtask

  task automatic step_clk();
    @(posedge clk);
    m_wait = n_wait; m_drain = n_drain; m_pend = n_pend; m_last = n_last;
    m_prev_redir = n_prev_redir; m_stall = n_stall; m_flushcnt = n_flushcnt;
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rst = 0; if_ready = 1; id_ready = 1; exe_done = 1; fw_valid = 1;
    mem_ready = 1; wb_ready = 1; if_busy = 0; mem_inflight = 0;
    br_redirect = 0; trap_req = 0;
  endtask

  task automatic idle_cycles(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) begin tick(); step_clk(); end
  endtask

  typedef struct {
    logic [5:0] rdy;      // {if, id, exe_done, fw_valid, mem, wb}
    logic [4:0] exp_adv;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{6'b111111, 5'b11111};
    vecs[1] = '{6'b111110, 5'b00000};
    vecs[2] = '{6'b111101, 5'b10000};
    vecs[3] = '{6'b110111, 5'b11000};
    vecs[4] = '{6'b111011, 5'b11000};
    vecs[5] = '{6'b101111, 5'b11100};
    vecs[6] = '{6'b011111, 5'b11110};
    vecs[7] = '{6'b011110, 5'b00000};

    m_wait = 0; m_drain = 0; m_prev_redir = 0; m_pend = '0; m_last = '0;
    m_stall = 0; m_flushcnt = 0;
    drive_idle();
    br_target = '0; trap_target = '0;
    rst = 1;

    // reset state
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_adv",   stage_adv,   5'b00000);
      chk("rst_flush", stage_flush, 5'b11111);
      chk("rst_redir", pc_redirect, 0);
      chk("rst_tgt",   pc_target,   0);
      chk("rst_busy",  busy,        0);
      step_clk();
    end

    // advance chain table
    drive_idle();
    foreach (vecs[i]) begin
      {if_ready, id_ready, exe_done, fw_valid, mem_ready, wb_ready} = vecs[i].rdy;
      tick();
      chk("tbl_adv",   stage_adv,   vecs[i].exp_adv);
      chk("tbl_flush", stage_flush, 5'b00000);
      chk("tbl_busy",  busy,        0);
      step_clk();
    end

    // load-use stall
    drive_idle();
    fw_valid = 0;
    for (int i = 0; i < 2; i++) begin
      tick(); chk("loaduse_adv", stage_adv, 5'b11000); step_clk();
    end
    fw_valid = 1;
    tick(); chk("loaduse_release", stage_adv, 5'b11111); step_clk();

    // branch redirect with idle fetch bus
    br_redirect = 1; br_target = 64'h8000_0100;
    tick();
    chk("br_flush", stage_flush, 5'b00011);
    chk("br_adv",   stage_adv,   5'b11100);
    chk("br_redir", pc_redirect, 1);
    chk("br_tgt",   pc_target,   64'h8000_0100);
    step_clk();
    br_redirect = 0; br_target = 64'h1234;
    tick();
    chk("br_pulse_end", pc_redirect, 0);
    chk("br_tgt_hold",  pc_target,   64'h8000_0100);
    step_clk();

    // branch redirect held while the fetch bus is busy for 3 cycles
    idle_cycles(1);
    br_redirect = 1; br_target = 64'h8000_0200; if_busy = 1;
    tick();
    chk("bw_flush0", stage_flush, 5'b00011);
    chk("bw_redir0", pc_redirect, 0);
    step_clk();
    br_redirect = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bw_busy",  busy,        1);
      chk("bw_flush", stage_flush, 5'b00001);
      chk("bw_adv",   stage_adv,   5'b11110);
      chk("bw_redir", pc_redirect, 0);
      step_clk();
    end
    if_busy = 0;
    tick();
    chk("bw_flush3", stage_flush, 5'b00001);
    chk("bw_redir3", pc_redirect, 1);
    chk("bw_tgt3",   pc_target,   64'h8000_0200);
    step_clk();
    tick(); chk("bw_back_run", busy, 0); step_clk();

    // trap beats branch, dbus outstanding for 2 cycles
    idle_cycles(1);
    trap_req = 1; trap_target = 64'h0000_0000_0000_0400;
    br_redirect = 1; br_target = 64'h8000_0300; mem_inflight = 1;
    tick();
    chk("tr_adv0",   stage_adv,   5'b10000);
    chk("tr_flush0", stage_flush, 5'b00000);
    chk("tr_redir0", pc_redirect, 0);
    step_clk();
    trap_req = 0; br_redirect = 1;
    tick();
    chk("tr_busy1",  busy,        1);
    chk("tr_adv1",   stage_adv,   5'b10000);
    chk("tr_flush1", stage_flush, 5'b00000);
    step_clk();
    mem_inflight = 0; br_redirect = 0;
    tick();
    chk("tr_flush2", stage_flush, 5'b01111);
    chk("tr_redir2", pc_redirect, 1);
    chk("tr_tgt2",   pc_target,   64'h400);
    step_clk();

    // reset while a redirect is parked
    idle_cycles(1);
    br_redirect = 1; br_target = 64'hdead_0000; if_busy = 1;
    tick(); step_clk();
    br_redirect = 0;
    tick(); chk("rw_busy", busy, 1); step_clk();
    rst = 1;
    tick();
    chk("rw_rst_flush", stage_flush, 5'b11111);
    chk("rw_rst_busy",  busy,        0);
    step_clk();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_no_redir", pc_redirect, 0);
      chk("rw_tgt_zero", pc_target,   0);
      step_clk();
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      if_ready     = ($urandom_range(0, 9) != 0);
      id_ready     = ($urandom_range(0, 9) != 0);
      exe_done     = ($urandom_range(0, 7) != 0);
      fw_valid     = ($urandom_range(0, 7) != 0);
      mem_ready    = ($urandom_range(0, 9) != 0);
      wb_ready     = ($urandom_range(0, 11) != 0);
      if_busy      = ($urandom_range(0, 9) < 4);
      mem_inflight = ($urandom_range(0, 9) < 4);
      br_redirect  = ($urandom_range(0, 9) == 0);
      trap_req     = ($urandom_range(0, 19) == 0);
      br_target    = {$urandom, $urandom};
      trap_target  = {$urandom, $urandom};
      tick();
      step_clk();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
